tnoc_flit_packet_arbiter: RTL and testbench
===========================================

Name: tnoc_flit_packet_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares one flit output channel between REQUESTERS flit sources.
- Typical use: merging the write-request and read-request flit streams of an AXI adapter, or several adapters, onto the single flit_out channel toward the fabric.
- Once a requester wins, it keeps the grant until its tail flit is accepted, so packets are never interleaved.
- The output is registered through a 2-entry skid buffer, giving full throughput and no combinational ready path from i_ready to o_ready.

Parameters:
- REQUESTERS, 2, number of flit sources (>=2).
- FLIT_WIDTH, 64, width of the flit payload passed through unmodified.
- LOCK_ON_HEAD, 1, 1 = hold the grant until the tail flit; 0 = re-arbitrate every flit (debug only).

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_valid  input  REQUESTERS  per-requester flit valid.
- o_ready  output  REQUESTERS  per-requester flit accepted (valid&ready = transfer).
- i_flit  input  REQUESTERS*FLIT_WIDTH  per-requester flit payload, requester k at [k*FLIT_WIDTH +: FLIT_WIDTH].
- i_tail  input  REQUESTERS  per-requester tail marker; 1 = last flit of packet.
- o_valid  output  1  output flit valid.
- i_ready  input  1  downstream ready.
- o_flit  output  FLIT_WIDTH  output flit payload.
- o_tail  output  1  output tail marker.
- o_grant  output  REQUESTERS  one-hot current grant; 0 when no grant.
- o_locked  output  1  a packet is in progress.

Behaviour:
- Reset (async on rst high):
  - state=IDLE, rr_pointer=0, skid buffer empty.
  - o_valid=0, o_ready=0, o_grant=0, o_locked=0, o_flit=0, o_tail=0.
- Definitions:
  - buf_ok = skid buffer has at least one free entry. The buffer holds 2 entries; buf_ok is a registered function of occupancy.
  - Transfer on requester k = i_valid[k] & o_ready[k].
- States: IDLE, LOCKED.
- IDLE:
  - If any i_valid and buf_ok: grant = first requester with i_valid set, searching from rr_pointer upward with wrap-around. This is combinational in the same cycle.
  - o_ready[grant]=1; all other o_ready bits are 0. The flit is accepted this cycle.
  - If the accepted flit has i_tail=1 (single-flit packet): stay IDLE and set rr_pointer=grant+1 mod REQUESTERS.
  - Otherwise: go to LOCKED, register owner=grant, and hold rr_pointer.
  - If no i_valid, or buf_ok=0: o_grant=0, all o_ready=0, no state change.
- LOCKED:
  - o_grant=onehot(owner); o_locked=1; o_ready[owner]=buf_ok; other o_ready bits are 0.
  - Other requesters are ignored even if valid.
  - Tail accepted from owner: go to IDLE and set rr_pointer=owner+1 mod REQUESTERS. The next arbitration happens in the following cycle; there is no same-cycle re-grant.
  - A LOCKED state with the owner's i_valid=0 (a bubble) is legal: hold the grant indefinitely.
- LOCK_ON_HEAD=0: LOCKED is never entered and rr_pointer advances after every accepted flit.
- Skid buffer:
  - An accepted flit appears on o_valid/o_flit/o_tail in the next cycle (latency 1).
  - o_valid stays high and o_flit stays stable until i_ready.
  - Sustained throughput is 1 flit/cycle when i_ready=1.
  - Two flits are stored with no loss when i_ready drops.
  - The buffer never overflows: o_ready is gated by buf_ok.
  - Flits leave in acceptance order.
- Simultaneous events:
  - A buffer pop and push in the same cycle with occupancy 2: the push is not allowed, because buf_ok was 0.
  - Occupancy 1 with push and pop: occupancy stays 1.
- Assertions, simulation only:
  - o_grant is one-hot or zero.
  - o_ready is a subset of o_grant.
  - i_flit and i_tail of the owner are stable while i_valid=1 and o_ready=0.
- Mid-packet reset: the partial packet is discarded with no output. The upstream requester is also reset by rst and must restart at a head flit.

Decomposition:
- Shared package (tnoc_flit_arbiter_pkg):
  - state enum {IDLE, LOCKED}.
  - function rr_select(valid, pointer) returning a one-hot vector.
  - function onehot_to_index.
- Sub-module tnoc_flit_skid_buffer (parameter WIDTH = FLIT_WIDTH+1): 2-entry valid/ready register slice with a registered not_full output.

Test Plan (REQUESTERS=2, FLIT_WIDTH=8):
1. Req0 sends a 3-flit packet 0x11,0x12,0x13(tail) with i_ready=1, and req1 is valid from cycle 1 with 0x21(tail):
   - Output order is 0x11,0x12,0x13,0x21, first flit 1 cycle after acceptance.
   - o_ready[1]=0 until the cycle after 0x13 is accepted.
2. Both requesters continuously send single-flit packets (req0: 0xA0.., req1: 0xB0..):
   - Grants alternate 0,1,0,1 and output alternates 0xA0,0xB0,0xA1,0xB1.
   - Full 1 flit/cycle after the first cycle.
3. Req0 streams 4 flits while i_ready is held at 0 for 5 cycles from cycle 2:
   - Exactly 2 flits are buffered, o_ready[0]=0 afterwards, and o_flit stays 0x11.
   - After i_ready=1 all 4 flits arrive in order with no loss or duplication.
4. Req1 is granted for a 2-flit packet, then its i_valid drops for 3 cycles between head and tail while req0 is valid:
   - o_grant stays 2'b10 and o_locked=1 throughout.
   - Req0 is not accepted until req1's tail transfers.
5. rst is asserted mid-packet (after the head was accepted, with 1 flit buffered):
   - o_valid=0, o_grant=0, o_locked=0 immediately (async).
   - After release, req1 valid is granted first (rr_pointer=0, req0 idle).
6. LOCK_ON_HEAD=0, both requesters send 2-flit packets:
   - Flits interleave 0x11,0x21,0x12,0x22.
   - The assertion checks remain clean.

Source files
------------

// File: rtl/tnoc_flit_arbiter_pkg.sv
// Shared types and helpers for the packet-locked flit arbiter.
// Vectors are sized for up to MAX_REQ requesters; unused upper bits are zero.
package tnoc_flit_arbiter_pkg;

    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    typedef logic [MAX_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0]   req_idx_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    // Wrapping at MAX_REQ visits the same order as wrapping at the real
    // requester count, because the bits above it are always zero.
    function automatic req_vec_t rr_select(input req_vec_t valid, input req_idx_t pointer);
        req_vec_t sel;
        logic     found;
        req_idx_t idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = pointer + req_idx_t'(i);
            if (!found && valid[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic req_idx_t onehot_to_index(input req_vec_t onehot);
        req_idx_t idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = idx | req_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tnoc_flit_skid_buffer.sv
// Two-entry valid/ready register slice. o_not_full is registered so that the
// upstream accept path never depends combinationally on i_ready.
module tnoc_flit_skid_buffer #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_not_full,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             not_full_q, not_full_d;
    logic             push, pop;

    always_comb begin
        push     = i_valid && not_full_q;
        pop      = (count_q != 2'd0) && i_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        not_full_d = (count_d != 2'd2);
    end

    // not_full starts at 0 so nothing can be granted while rst is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            not_full_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            not_full_q <= not_full_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_not_full = not_full_q;
    assign o_valid    = (count_q != 2'd0);
    assign o_data     = o_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/tnoc_flit_packet_arbiter.sv
// Round-robin arbiter merging REQUESTERS flit streams onto one channel,
// holding the grant from head to tail so packets never interleave.
module tnoc_flit_packet_arbiter #(
    parameter int REQUESTERS   = 2,
    parameter int FLIT_WIDTH   = 64,
    parameter int LOCK_ON_HEAD = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [REQUESTERS-1:0]            i_valid,
    output logic [REQUESTERS-1:0]            o_ready,
    input  logic [REQUESTERS*FLIT_WIDTH-1:0] i_flit,
    input  logic [REQUESTERS-1:0]            i_tail,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [FLIT_WIDTH-1:0]            o_flit,
    output logic                             o_tail,
    output logic [REQUESTERS-1:0]            o_grant,
    output logic                             o_locked
);
    import tnoc_flit_arbiter_pkg::*;

    localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] win_sel;
    req_vec_t         sel_vec;
    logic             buf_ok;
    logic             push;
    logic [FLIT_WIDTH:0] push_data;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(REQUESTERS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        o_grant  = '0;
        o_ready  = '0;
        push     = 1'b0;
        win_sel  = owner_q;
        sel_vec  = rr_select(req_vec_t'(i_valid), req_idx_t'(rr_ptr_q));
        case (state_q)
            IDLE: begin
                if (buf_ok && (|i_valid)) begin
                    win_sel = PTR_W'(onehot_to_index(sel_vec));
                    o_grant = sel_vec[REQUESTERS-1:0];
                    o_ready = sel_vec[REQUESTERS-1:0];
                    push    = 1'b1;
                    if (i_tail[win_sel] || (LOCK_ON_HEAD == 0)) begin
                        rr_ptr_d = next_ptr(win_sel);
                    end else begin
                        state_d = LOCKED;
                        owner_d = win_sel;
                    end
                end
            end
            LOCKED: begin
                // Other requesters are ignored; a bubble from the owner simply holds.
                o_grant = REQUESTERS'(1) << owner_q;
                o_ready = buf_ok ? o_grant : '0;
                push    = buf_ok && i_valid[owner_q];
                if (push && i_tail[owner_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr(owner_q);
                end
            end
            default: state_d = IDLE;
        endcase
        push_data = {i_tail[win_sel], i_flit[win_sel*FLIT_WIDTH +: FLIT_WIDTH]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            o_locked <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            o_locked <= (state_d == LOCKED);
        end
    end

    tnoc_flit_skid_buffer #(
        .WIDTH (FLIT_WIDTH + 1)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (push),
        .o_not_full (buf_ok),
        .i_data     (push_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     ({o_tail, o_flit})
    );

`ifndef SYNTHESIS
    logic [FLIT_WIDTH-1:0] owner_flit;
    assign owner_flit = i_flit[owner_q*FLIT_WIDTH +: FLIT_WIDTH];

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(o_grant));
    a_ready_in_grant: assert property (@(posedge clk) disable iff (rst)
        ((o_ready & ~o_grant) == '0));
    a_owner_stable: assert property (@(posedge clk) disable iff (rst)
        (state_q == LOCKED && i_valid[owner_q] && !o_ready[owner_q]) |=>
        (!i_valid[owner_q] || ($stable(owner_flit) && $stable(i_tail[owner_q]))));
`endif

endmodule

// File: tb/tb_tnoc_flit_packet_arbiter.sv
// Bench for tnoc_flit_packet_arbiter: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_tnoc_flit_packet_arbiter;
    localparam int N = 2;
    localparam int W = 8;
    typedef logic [W:0] fl_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] i_valid = '0, o_ready, i_tail = '0, o_grant;
    logic [N*W-1:0] i_flit = '0;
    logic         o_valid, i_ready = 1'b1, o_tail, o_locked;
    logic [W-1:0] o_flit;

    logic [N-1:0] i_valid_b = '0, o_ready_b, i_tail_b = '0, o_grant_b;
    logic [N*W-1:0] i_flit_b = '0;
    logic         o_valid_b, i_ready_b = 1'b1, o_tail_b, o_locked_b;
    logic [W-1:0] o_flit_b;

    always #5 clk = ~clk;

    tnoc_flit_packet_arbiter #(.REQUESTERS(N), .FLIT_WIDTH(W), .LOCK_ON_HEAD(1)) u_dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_flit(i_flit),
        .i_tail(i_tail), .o_valid(o_valid), .i_ready(i_ready), .o_flit(o_flit),
        .o_tail(o_tail), .o_grant(o_grant), .o_locked(o_locked));

    tnoc_flit_packet_arbiter #(.REQUESTERS(N), .FLIT_WIDTH(W), .LOCK_ON_HEAD(0)) u_dut_nolock (
        .clk(clk), .rst(rst), .i_valid(i_valid_b), .o_ready(o_ready_b), .i_flit(i_flit_b),
        .i_tail(i_tail_b), .o_valid(o_valid_b), .i_ready(i_ready_b), .o_flit(o_flit_b),
        .o_tail(o_tail_b), .o_grant(o_grant_b), .o_locked(o_locked_b));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-requester packet sources; stall_rand inserts bubbles, rdy_rand toggles i_ready.
    fl_t pq [N][$];
    bit  stall_rand = 0;
    bit  rdy_rand = 0;

    always begin : drv
        logic [N-1:0] xfer;
        fl_t f;
        @(negedge clk);
        xfer = rst ? '0 : (i_valid & o_ready);
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (xfer[k] && pq[k].size() > 0) void'(pq[k].pop_front());
            i_valid[k] = (pq[k].size() > 0) && !(stall_rand && ($urandom_range(0, 3) == 0));
            if (pq[k].size() > 0) begin
                f = pq[k][0];
                i_flit[k*W +: W] = f[W-1:0];
                i_tail[k] = f[W];
            end
        end
        if (rdy_rand) i_ready = ($urandom_range(0, 3) != 0);
    end

    // Reference model: output FIFO as a queue, arbitration from the rules directly.
    fl_t mq[$];
    bit  m_locked = 0, m_warm = 0;
    int  m_owner = 0, m_rr = 0, cyc = 0;
    fl_t outq[$];
    int  out_cyc[$];

    always @(negedge clk) begin : mdl
        logic [N-1:0] eg, er;
        bit  ok;
        int  win, k;
        fl_t f;
        cyc++;
        if (rst) begin
            chk("rst_o_valid", o_valid, 0);
            chk("rst_o_grant", o_grant, 0);
            chk("rst_o_ready", o_ready, 0);
            chk("rst_o_locked", o_locked, 0);
            chk("rst_o_flit", {o_tail, o_flit}, 0);
            mq.delete();
            m_locked = 0; m_rr = 0; m_warm = 0;
        end else begin
            ok = m_warm && (mq.size() < 2);
            eg = '0; er = '0; win = -1;
            if (m_locked) begin
                eg[m_owner] = 1'b1;
                if (ok) er = eg;
            end else if (ok) begin
                for (int i = 0; i < N; i++) begin
                    k = (m_rr + i) % N;
                    if (win < 0 && i_valid[k]) win = k;
                end
                if (win >= 0) begin eg[win] = 1'b1; er = eg; end
            end
            chk("o_grant", o_grant, eg);
            chk("o_ready", o_ready, er);
            chk("o_locked", o_locked, m_locked);
            chk("o_valid", o_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                f = mq[0];
                chk("o_flit", o_flit, f[W-1:0]);
                chk("o_tail", o_tail, f[W]);
            end
            if (o_valid && i_ready) begin
                outq.push_back({o_tail, o_flit});
                out_cyc.push_back(cyc);
            end
            if (mq.size() > 0 && i_ready) void'(mq.pop_front());
            for (int j = 0; j < N; j++) begin
                if (er[j] && i_valid[j]) begin
                    mq.push_back({i_tail[j], i_flit[j*W +: W]});
                    if (!m_locked) begin
                        if (i_tail[j]) m_rr = (j + 1) % N;
                        else begin m_locked = 1; m_owner = j; end
                    end else if (i_tail[j]) begin
                        m_locked = 0; m_rr = (j + 1) % N;
                    end
                end
            end
            m_warm = 1;
        end
    end

    logic [W-1:0] exp_q[$];

    task automatic check_out(input string name);
        fl_t f;
        chk({name, "_count"}, outq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < outq.size(); i++) begin
            f = outq[i];
            chk(name, f[W-1:0], exp_q[i]);
        end
    endtask

    task automatic drain(input string name, input int max);
        int  n;
        bit  done;
        n = 0; done = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
            done = (pq[0].size() == 0) && (pq[1].size() == 0) && (i_valid == '0) && !o_valid;
        end
        chk(name, done, 1);
    endtask

    task automatic start_test();
        outq.delete(); out_cyc.delete(); exp_q.delete();
    endtask

    initial begin : main
        int total, len, p0, p1;
        logic [W-1:0] got_b[$];
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);

        // 1: 3-flit packet from req0, req1 arrives one cycle later
        start_test();
        #2;
        pq[0].push_back({1'b0, 8'h11}); pq[0].push_back({1'b0, 8'h12}); pq[0].push_back({1'b1, 8'h13});
        @(posedge clk); #2;
        pq[1].push_back({1'b1, 8'h21});
        drain("t1_drain", 50);
        exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h13); exp_q.push_back(8'h21);
        check_out("t1_order");

        // 2: continuous single-flit packets from both
        start_test();
        @(posedge clk); #2;
        for (int i = 0; i < 4; i++) begin
            pq[0].push_back({1'b1, 8'(8'hA0 + i)});
            pq[1].push_back({1'b1, 8'(8'hB0 + i)});
            exp_q.push_back(8'(8'hA0 + i));
            exp_q.push_back(8'(8'hB0 + i));
        end
        drain("t2_drain", 50);
        check_out("t2_order");
        chk("t2_rate", (out_cyc.size() == 8) ? out_cyc[7] - out_cyc[0] : 0, 7);

        // 3: downstream stall of 5 cycles
        start_test();
        @(posedge clk); #2;
        for (int i = 0; i < 4; i++) begin
            pq[0].push_back({i == 3, 8'(8'h11 + i)});
            exp_q.push_back(8'(8'h11 + i));
        end
        @(posedge clk); #2;
        @(posedge clk); #2;
        i_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t3_hold_valid", o_valid, 1);
        chk("t3_hold_flit", o_flit, 8'h11);
        chk("t3_hold_ready", o_ready[0], 0);
        chk("t3_no_out", outq.size(), 0);
        @(posedge clk); #2;
        i_ready = 1'b1;
        drain("t3_drain", 50);
        check_out("t3_order");

        // 4: bubble between head and tail holds the lock
        start_test();
        @(posedge clk); #2;
        pq[1].push_back({1'b0, 8'h41});
        pq[0].push_back({1'b1, 8'h31});
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t4_grant", o_grant, 2'b10);
            chk("t4_locked", o_locked, 1);
            chk("t4_ready0", o_ready[0], 0);
        end
        pq[1].push_back({1'b1, 8'h42});
        drain("t4_drain", 50);
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h31);
        check_out("t4_order");

        // 5: reset mid-packet
        start_test();
        i_ready = 1'b0;
        @(posedge clk); #2;
        pq[0].push_back({1'b0, 8'h51}); pq[0].push_back({1'b0, 8'h52}); pq[0].push_back({1'b1, 8'h53});
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        pq[0].delete();
        #1;
        chk("t5_valid", o_valid, 0);
        chk("t5_grant", o_grant, 0);
        chk("t5_locked", o_locked, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        i_ready = 1'b1;
        start_test();
        pq[1].push_back({1'b1, 8'h61});
        drain("t5_drain", 50);
        exp_q.push_back(8'h61);
        check_out("t5_order");

        // random traffic
        start_test();
        total = 0;
        stall_rand = 1; rdy_rand = 1;
        repeat (500) begin
            @(posedge clk); #2;
            for (int k = 0; k < N; k++) begin
                if (pq[k].size() < 8 && $urandom_range(0, 3) == 0) begin
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++) pq[k].push_back({j == len - 1, 8'($urandom)});
                    total += len;
                end
            end
        end
        @(posedge clk); #2;
        stall_rand = 0; rdy_rand = 0; i_ready = 1'b1;
        drain("rand_drain", 500);
        chk("rand_count", outq.size(), total);

        // 6: LOCK_ON_HEAD=0 interleaves per flit
        p0 = 0; p1 = 0;
        for (int c = 0; c < 20 && (p0 < 2 || p1 < 2 || o_valid_b); c++) begin
            @(posedge clk); #2;
            i_valid_b[0] = (p0 < 2); i_flit_b[W-1:0] = (p0 == 0) ? 8'h11 : 8'h12; i_tail_b[0] = (p0 == 1);
            i_valid_b[1] = (p1 < 2); i_flit_b[2*W-1:W] = (p1 == 0) ? 8'h21 : 8'h22; i_tail_b[1] = (p1 == 1);
            @(negedge clk);
            if (o_valid_b && i_ready_b) got_b.push_back(o_flit_b);
            chk("t6_locked", o_locked_b, 0);
            if (i_valid_b[0] && o_ready_b[0]) p0++;
            if (i_valid_b[1] && o_ready_b[1]) p1++;
        end
        chk("t6_count", got_b.size(), 4);
        if (got_b.size() == 4) begin
            chk("t6_f0", got_b[0], 8'h11);
            chk("t6_f1", got_b[1], 8'h21);
            chk("t6_f2", got_b[2], 8'h12);
            chk("t6_f3", got_b[3], 8'h22);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
